// File: rtl/game_flow_if.sv
// rtl/game_flow_if.sv - control/status bundle between the game sequencer and its datapath peers
interface game_flow_if #(
    parameter int SCORE_W = 10
);
    logic               frame_en;
    logic               btn_pulse;
    logic               collision;
    logic               score_pulse;
    logic               game_active;
    logic               flap_pulse;
    logic [2:0]         state;
    logic [7:0]         countdown;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               new_record;

    modport master (
        output frame_en, btn_pulse, collision, score_pulse,
        input  game_active, flap_pulse, state, countdown, score, high_score, new_record
    );

    modport slave (
        input  frame_en, btn_pulse, collision, score_pulse,
        output game_active, flap_pulse, state, countdown, score, high_score, new_record
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - IDLE/READY/PLAY/DYING/OVER sequencer with score and session high score
module game_flow_ctrl #(
    parameter int READY_FRAMES = 60,
    parameter int DEATH_FRAMES = 90,
    parameter int SCORE_W      = 10,
    parameter int SCORE_MAX    = 999
) (
    input logic         clk,
    input logic         rst_n,
    game_flow_if.slave  gif
);
    localparam int FCNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        DYING = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t             st;
    logic [FCNT_W-1:0]  fcnt;
    logic [7:0]         countdown_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] high_q;
    logic               record_q;
    logic               active_q;
    logic               flap_q;

    // Every output is updated alongside the state register so it always matches st.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            fcnt        <= '0;
            countdown_q <= '0;
            score_q     <= '0;
            high_q      <= '0;
            record_q    <= 1'b0;
            active_q    <= 1'b0;
            flap_q      <= 1'b0;
        end else begin
            flap_q <= 1'b0;
            case (st)
                IDLE, OVER: begin
                    if (gif.btn_pulse) begin
                        st          <= READY;
                        fcnt        <= '0;
                        countdown_q <= 8'(READY_FRAMES);
                        score_q     <= '0;
                        record_q    <= 1'b0;
                        active_q    <= 1'b0;
                    end else if (gif.frame_en) begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                READY: begin
                    if (gif.frame_en) begin
                        if (fcnt == FCNT_W'(READY_FRAMES - 1)) begin
                            st          <= PLAY;
                            fcnt        <= '0;
                            countdown_q <= '0;
                            active_q    <= 1'b1;
                        end else begin
                            fcnt        <= fcnt + 1'b1;
                            countdown_q <= 8'(READY_FRAMES) - fcnt - 8'd1;
                        end
                    end
                end
                PLAY: begin
                    flap_q <= gif.btn_pulse;
                    // A collision in the same clock as a pipe pass cancels the point.
                    if (gif.collision) begin
                        st       <= DYING;
                        fcnt     <= '0;
                        active_q <= 1'b0;
                    end else begin
                        if (gif.score_pulse && score_q != SCORE_W'(SCORE_MAX))
                            score_q <= score_q + SCORE_W'(1);
                        if (gif.frame_en)
                            fcnt <= fcnt + 1'b1;
                    end
                end
                DYING: begin
                    if (gif.frame_en) begin
                        if (fcnt == FCNT_W'(DEATH_FRAMES - 1)) begin
                            st   <= OVER;
                            fcnt <= '0;
                            if (score_q > high_q) begin
                                high_q   <= score_q;
                                record_q <= 1'b1;
                            end else begin
                                record_q <= 1'b0;
                            end
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    st          <= IDLE;
                    fcnt        <= '0;
                    countdown_q <= '0;
                    active_q    <= 1'b0;
                end
            endcase
        end
    end

    assign gif.state       = st;
    assign gif.countdown   = countdown_q;
    assign gif.score       = score_q;
    assign gif.high_score  = high_q;
    assign gif.new_record  = record_q;
    assign gif.game_active = active_q;
    assign gif.flap_pulse  = flap_q;
endmodule
